// File: rtl/raster_coord_gen_if.sv
// Stream interface carrying one raster coordinate beat per valid/ready handshake.
//   valid  : beat present on x/y/flags (source -> sink)
//   ready  : sink accepts the current beat (sink -> source)
//   x, y   : signed pixel coordinate
//   first  : first pixel of the frame
//   lastx  : last pixel of a row
//   lasty  : beat lies on the last row
//   last   : end of frame (lastx & lasty)
interface raster_coord_gen_if #(
    parameter int COORD_W = 16
) ();
    logic                      valid;
    logic                      ready;
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic                      first;
    logic                      lastx;
    logic                      lasty;
    logic                      last;

    modport master (
        output valid, x, y, first, lastx, lasty, last,
        input  ready
    );

    modport slave (
        input  valid, x, y, first, lastx, lasty, last,
        output ready
    );
endinterface

// File: rtl/raster_coord_gen.sv
// Raster scan coordinate source. Emits one signed (x,y) coordinate per accepted
// beat, row by row, with first/end-of-row/end-of-frame markers, and counts
// completed frames. Scanning starts on a start pulse, optionally rolls straight
// into the next frame, and halts at a frame boundary on stop.
// Ports:
//   clk        : clock
//   resetn     : synchronous reset, active low
//   start      : pulse, begins scanning when idle
//   continuous : sampled on the end-of-frame beat, 1 = roll into next frame
//   stop       : pulse, halt at the end of the current frame
//   bus        : coordinate stream (master side: valid/x/y/flags out, ready in)
//   busy       : scanning in progress
//   done       : one-cycle pulse on return to idle after a frame
//   frame_cnt  : frames completed since reset, wraps
module raster_coord_gen #(
    parameter int COORD_W = 16,
    parameter int X_SIZE  = 512,
    parameter int Y_SIZE  = 512,
    parameter bit CENTRED = 1'b1,
    parameter bit Y_DOWN  = 1'b1,
    parameter int FCNT_W  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    raster_coord_gen_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam longint COORD_MAX = (64'sd1 <<< (COORD_W - 1)) - 64'sd1;

    localparam int X_START_I = CENTRED ? -(X_SIZE / 2) : 0;
    localparam int X_END_I   = CENTRED ? (X_SIZE / 2) - 1 : X_SIZE - 1;
    localparam int Y_MIN_I   = CENTRED ? 1 - (Y_SIZE / 2) : 0;
    localparam int Y_MAX_I   = CENTRED ? (Y_SIZE / 2) : Y_SIZE - 1;
    localparam int Y_START_I = Y_DOWN ? Y_MAX_I : Y_MIN_I;
    localparam int Y_END_I   = Y_DOWN ? Y_MIN_I : Y_MAX_I;
    localparam int Y_STEP_I  = Y_DOWN ? -1 : 1;

    localparam logic signed [COORD_W-1:0] X_START = COORD_W'(X_START_I);
    localparam logic signed [COORD_W-1:0] X_END   = COORD_W'(X_END_I);
    localparam logic signed [COORD_W-1:0] Y_START = COORD_W'(Y_START_I);
    localparam logic signed [COORD_W-1:0] Y_END   = COORD_W'(Y_END_I);
    localparam logic signed [COORD_W-1:0] Y_STEP  = COORD_W'(Y_STEP_I);
    localparam logic signed [COORD_W-1:0] X_ONE   = COORD_W'(1);
    localparam logic [FCNT_W-1:0]         F_ONE   = FCNT_W'(1);

    localparam bit BAD_SIZE  = (X_SIZE < 2) || (Y_SIZE < 2) ||
                               (CENTRED && ((X_SIZE % 2) != 0 || (Y_SIZE % 2) != 0));
    localparam bit BAD_RANGE = CENTRED ?
        ((longint'(X_SIZE / 2) > COORD_MAX) || (longint'(Y_SIZE / 2) > COORD_MAX)) :
        ((longint'(X_SIZE - 1) > COORD_MAX) || (longint'(Y_SIZE - 1) > COORD_MAX));

    if (BAD_SIZE) begin : g_bad_size
        $error("raster_coord_gen: X_SIZE/Y_SIZE must be >= 2 and even when CENTRED");
    end
    if (BAD_RANGE) begin : g_bad_range
        $error("raster_coord_gen: COORD_W too narrow for the frame coordinates");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                state_q, state_d;
    logic signed [COORD_W-1:0] x_q, x_d;
    logic signed [COORD_W-1:0] y_q, y_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      stop_pend_q, stop_pend_d;
    logic [FCNT_W-1:0]         fcnt_q, fcnt_d;

    logic at_x_start;
    logic at_y_start;
    logic at_x_end;
    logic at_y_end;
    logic accept;
    logic keep_running;

    // Position decodes straight off the coordinate registers; valid gates the
    // exported flags so they are never seen asserted between frames.
    assign at_x_start = (x_q == X_START);
    assign at_y_start = (y_q == Y_START);
    assign at_x_end   = (x_q == X_END);
    assign at_y_end   = (y_q == Y_END);
    assign accept     = valid_q & bus.ready;

    // A stop arriving on the very last beat must still end the run, so the
    // live stop input is considered alongside the pending flag.
    assign keep_running = continuous & ~stop_pend_q & ~stop;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        fcnt_d      = fcnt_q;

        case (state_q)
            IDLE: begin
                valid_d     = 1'b0;
                stop_pend_d = 1'b0;
                x_d         = X_START;
                y_d         = Y_START;
                if (start) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    if (at_x_end && at_y_end) begin
                        fcnt_d = fcnt_q + F_ONE;
                        x_d    = X_START;
                        y_d    = Y_START;
                        if (!keep_running) begin
                            state_d     = IDLE;
                            valid_d     = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end
                    end else if (!at_x_end) begin
                        x_d = x_q + X_ONE;
                    end else begin
                        x_d = X_START;
                        y_d = y_q + Y_STEP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            x_q         <= X_START;
            y_q         <= Y_START;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.first = valid_q & at_x_start & at_y_start;
    assign bus.lastx = valid_q & at_x_end;
    assign bus.lasty = valid_q & at_y_end;
    assign bus.last  = valid_q & at_x_end & at_y_end;

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = fcnt_q;

endmodule
